// File: rtl/im_fetch_ctrl.sv
// im_fetch_ctrl: sequencer/arbiter in front of a byte-wide instruction memory.
// Word fetches become four consecutive byte reads assembled big-endian; a byte
// loader shares the single memory port under round-robin arbitration; bad
// fetch addresses are answered with an error response without touching memory.
module im_fetch_ctrl #(
  parameter int MEM_SIZE = 128,
  localparam int AW = $clog2(MEM_SIZE)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  input  logic [31:0]   req_addr,
  output logic          req_ready,
  output logic          resp_valid,
  output logic [31:0]   resp_instr,
  output logic          resp_err,
  input  logic          resp_ready,
  input  logic          ld_valid,
  input  logic [AW-1:0] ld_addr,
  input  logic [7:0]    ld_data,
  output logic          ld_ready,
  output logic          mem_rd_en,
  output logic          mem_wr_en,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_wdata,
  input  logic [7:0]    mem_rdata
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, RESP} state_e;

  state_e        state_q, state_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [AW-1:0] base_q, base_d;
  logic          lastGrantFetch_q, lastGrantFetch_d;
  logic [31:0]   resp_instr_q;
  logic          resp_err_q;
  logic          grantFetch;
  logic          grantLoad;
  logic          reqErr;

  // Misaligned or past the last full word; the whole 32-bit address is compared
  // so high garbage bits cannot alias back into the array.
  assign reqErr = (req_addr[1:0] != 2'b00) || (req_addr > 32'(MEM_SIZE - 4));

  assign resp_valid = (state_q == RESP);
  assign resp_instr = resp_instr_q;
  assign resp_err   = resp_err_q;
  assign mem_wdata  = ld_data;

  // State, byte counter, latched base address and round-robin history.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      cnt_q            <= 2'd0;
      base_q           <= '0;
      lastGrantFetch_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      base_q           <= base_d;
      lastGrantFetch_q <= lastGrantFetch_d;
    end
  end

  // Arbitration in IDLE, read sequencing, and memory strobes; the loader only
  // ever wins while idle, so it can never cut into a fetch in flight.
  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    base_d           = base_q;
    lastGrantFetch_d = lastGrantFetch_q;
    grantFetch       = 1'b0;
    grantLoad        = 1'b0;
    req_ready        = 1'b0;
    ld_ready         = 1'b0;
    mem_rd_en        = 1'b0;
    mem_wr_en        = 1'b0;
    mem_addr         = '0;
    case (state_q)
      IDLE: begin
        grantFetch = req_valid && (!ld_valid || !lastGrantFetch_q);
        grantLoad  = ld_valid && !grantFetch;
        if (grantLoad) begin
          ld_ready         = 1'b1;
          mem_wr_en        = 1'b1;
          mem_addr         = ld_addr;
          lastGrantFetch_d = 1'b0;
        end
        if (grantFetch) begin
          req_ready        = 1'b1;
          lastGrantFetch_d = 1'b1;
          if (reqErr) begin
            state_d = RESP;
          end else begin
            state_d = READ;
            cnt_d   = 2'd0;
            base_d  = req_addr[AW-1:0];
          end
        end
      end
      READ: begin
        mem_rd_en = 1'b1;
        mem_addr  = base_q + AW'(cnt_q);
        cnt_d     = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        state_d = RESP;
      end
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Response register: cleared on accept, then each byte lands one cycle after
  // its read was issued, most significant byte first.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_instr_q <= '0;
      resp_err_q   <= 1'b0;
    end else if (grantFetch) begin
      resp_instr_q <= '0;
      resp_err_q   <= reqErr;
    end else if (state_q == READ) begin
      case (cnt_q)
        2'd1:    resp_instr_q[31:24] <= mem_rdata;
        2'd2:    resp_instr_q[23:16] <= mem_rdata;
        2'd3:    resp_instr_q[15:8]  <= mem_rdata;
        default: ;
      endcase
    end else if (state_q == DRAIN) begin
      resp_instr_q[7:0] <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_im_fetch_ctrl.sv
// tb_im_fetch_ctrl: byte memory harness, transaction-level reference model with
// per-cycle comparison, directed scenarios with literal expectations, then
// randomized traffic.
module tb_im_fetch_ctrl;

  localparam int MEM_SIZE = 128;
  localparam int AW = $clog2(MEM_SIZE);

  logic          clk;
  logic          rst;
  logic          req_valid;
  logic [31:0]   req_addr;
  logic          req_ready;
  logic          resp_valid;
  logic [31:0]   resp_instr;
  logic          resp_err;
  logic          resp_ready;
  logic          ld_valid;
  logic [AW-1:0] ld_addr;
  logic [7:0]    ld_data;
  logic          ld_ready;
  logic          mem_rd_en;
  logic          mem_wr_en;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic [7:0]    mem_rdata;

  int checks = 0;
  int passes = 0;
  bit compareOn = 1'b0;

  im_fetch_ctrl #(.MEM_SIZE(MEM_SIZE)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_instr (resp_instr),
    .resp_err   (resp_err),
    .resp_ready (resp_ready),
    .ld_valid   (ld_valid),
    .ld_addr    (ld_addr),
    .ld_data    (ld_data),
    .ld_ready   (ld_ready),
    .mem_rd_en  (mem_rd_en),
    .mem_wr_en  (mem_wr_en),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Initial memory image; bytes 8..11 hold a known word.
  function automatic logic [7:0] initByte(input int i);
    case (i)
      8:       return 8'h12;
      9:       return 8'h34;
      10:      return 8'h56;
      11:      return 8'h78;
      default: return 8'(i * 37 + 5);
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Byte memory seen by the DUT: one-cycle read latency, write at posedge.
  logic [7:0] mem [MEM_SIZE];
  logic [7:0] rdataQ;
  assign mem_rdata = rdataQ;

  initial begin
    rdataQ <= 8'h00;
    for (int i = 0; i < MEM_SIZE; i++) mem[i] <= initByte(i);
    forever begin
      @(posedge clk);
      if (mem_wr_en) mem[mem_addr] <= mem_wdata;
      if (mem_rd_en) rdataQ <= mem[mem_addr];
    end
  end

  // Reference model: a fetch is tracked by the number of edges since it was
  // accepted; reads occupy ages 1..4 and the response appears at age 6
  // (age 1 for a rejected address).
  logic [7:0]  refMem [MEM_SIZE];
  bit          inFlight;
  bit          mLastFetch;
  int          age;
  int          respAt;
  int          mBase;
  logic [31:0] mInstr;
  bit          mErr;

  function automatic logic isBad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a > 32'(MEM_SIZE - 4));
  endfunction

  function automatic logic wantFetch();
    return req_valid && (!ld_valid || !mLastFetch);
  endfunction

  initial begin
    inFlight = 1'b0; mLastFetch = 1'b0; age = 0; respAt = 0; mBase = 0;
    mInstr = '0; mErr = 1'b0;
    for (int i = 0; i < MEM_SIZE; i++) refMem[i] = initByte(i);
    forever begin
      @(posedge clk);
      if (rst) begin
        inFlight   = 1'b0;
        mLastFetch = 1'b0;
      end else if (!inFlight) begin
        if (wantFetch()) begin
          mLastFetch = 1'b1;
          inFlight   = 1'b1;
          age        = 1;
          mErr       = isBad(req_addr);
          respAt     = mErr ? 1 : 6;
          mBase      = int'(req_addr[AW-1:0]);
          mInstr     = mErr ? 32'h0 :
                       {refMem[mBase], refMem[mBase+1], refMem[mBase+2], refMem[mBase+3]};
        end else if (ld_valid) begin
          mLastFetch      = 1'b0;
          refMem[ld_addr] = ld_data;
        end
      end else if (age >= respAt) begin
        if (resp_ready) inFlight = 1'b0;
      end else begin
        age++;
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  logic          eReq, eLd, eRd, eWr, eValid;
  logic [AW-1:0] eAddr;

  always @(negedge clk) begin
    if (compareOn) begin
      eReq = 1'b0; eLd = 1'b0; eRd = 1'b0; eWr = 1'b0; eValid = 1'b0; eAddr = '0;
      if (!inFlight) begin
        if (wantFetch()) eReq = 1'b1;
        else if (ld_valid) begin
          eLd = 1'b1; eWr = 1'b1; eAddr = ld_addr;
        end
      end else if (age >= respAt) begin
        eValid = 1'b1;
      end else if (age <= 4) begin
        eRd = 1'b1; eAddr = AW'(mBase + age - 1);
      end
      checkOutput("req_ready", 32'(req_ready), 32'(eReq));
      checkOutput("ld_ready", 32'(ld_ready), 32'(eLd));
      checkOutput("mem_rd_en", 32'(mem_rd_en), 32'(eRd));
      checkOutput("mem_wr_en", 32'(mem_wr_en), 32'(eWr));
      checkOutput("mem_addr", 32'(mem_addr), 32'(eAddr));
      checkOutput("resp_valid", 32'(resp_valid), 32'(eValid));
      if (eValid) begin
        checkOutput("resp_instr", resp_instr, mInstr);
        checkOutput("resp_err", 32'(resp_err), 32'(mErr));
      end
      if (eWr) checkOutput("mem_wdata", 32'(mem_wdata), 32'(ld_data));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic rv, input logic [31:0] ra, input logic lv,
                               input logic [AW-1:0] la, input logic [7:0] ld,
                               input logic rr, input logic rs);
    req_valid = rv; req_addr = ra; ld_valid = lv; ld_addr = la; ld_data = ld;
    resp_ready = rr; rst = rs;
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 32'h0, 1'b0, '0, 8'h00, 1'b0, 1'b1);
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Raise a request and hold it until accepted; returns just after the accept edge.
  task automatic startFetch(input logic [31:0] a);
    int n = 0;
    req_valid = 1'b1; req_addr = a; resp_ready = 1'b0;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("acceptWait", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
  endtask

  // Count cycles from the accept edge until resp_valid; returns on a negedge.
  task automatic waitResp(output int lat);
    lat = 1;
    @(negedge clk);
    while (!resp_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("respWait", 32'(resp_valid), 32'd1);
  endtask

  task automatic finishResp();
    tick();
    resp_ready = 1'b1; req_valid = 1'b0;
    tick();
    resp_ready = 1'b0;
  endtask

  task automatic fetchWord(input logic [31:0] a, output logic [31:0] instr,
                           output logic err, output int lat);
    startFetch(a);
    waitResp(lat);
    instr = resp_instr;
    err   = resp_err;
    finishResp();
  endtask

  task automatic loadByte(input logic [AW-1:0] a, input logic [7:0] d);
    int n = 0;
    ld_valid = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clk);
    while (!ld_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("loadWait", 32'(ld_ready), 32'd1);
    tick();
    ld_valid = 1'b0;
  endtask

  logic [31:0] instr;
  logic        err;
  int          lat;
  int          g [4];
  int          ng;
  logic [31:0] badAddrs [3];
  logic [31:0] goodAddrs [2];
  logic [31:0] ra;
  int          kind;

  initial begin
    badAddrs  = '{32'h6, 32'h80, 32'h100};
    goodAddrs = '{32'h7C, 32'h78};
    applyStimulus(1'b0, 32'h0, 1'b0, '0, 8'h00, 1'b0, 1'b1);
    tick();
    compareOn = 1'b1;
    tick();
    rst = 1'b0;

    @(negedge clk);
    checkOutput("rstRespValid", 32'(resp_valid), 32'd0);
    checkOutput("rstRespInstr", resp_instr, 32'h0);
    checkOutput("rstRespErr", 32'(resp_err), 32'd0);
    checkOutput("rstRdEn", 32'(mem_rd_en), 32'd0);
    tick();

    fetchWord(32'h8, instr, err, lat);
    checkOutput("fetch8Instr", instr, 32'h12345678);
    checkOutput("fetch8Err", 32'(err), 32'd0);
    checkOutput("fetch8Latency", 32'(lat), 32'd6);

    foreach (badAddrs[i]) begin
      fetchWord(badAddrs[i], instr, err, lat);
      checkOutput($sformatf("badErr_%0h", badAddrs[i]), 32'(err), 32'd1);
      checkOutput($sformatf("badInstr_%0h", badAddrs[i]), instr, 32'h0);
      checkOutput($sformatf("badLatency_%0h", badAddrs[i]), 32'(lat), 32'd1);
    end

    foreach (goodAddrs[i]) begin
      fetchWord(goodAddrs[i], instr, err, lat);
      checkOutput($sformatf("edgeErr_%0h", goodAddrs[i]), 32'(err), 32'd0);
      checkOutput($sformatf("edgeLatency_%0h", goodAddrs[i]), 32'(lat), 32'd6);
    end

    // Both requesters held: grants must alternate starting with the fetch.
    doReset();
    for (int k = 0; k < 4; k++) g[k] = 2;
    ng = 0;
    applyStimulus(1'b1, 32'h0, 1'b1, AW'(7'h40), 8'h5A, 1'b1, 1'b0);
    for (int c = 0; c < 60 && ng < 4; c++) begin
      @(negedge clk);
      if (req_ready) begin
        g[ng] = 1; ng++;
      end else if (ld_ready) begin
        g[ng] = 0; ng++;
      end
    end
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, '0, 8'h00, 1'b1, 1'b0);
    repeat (8) tick();
    resp_ready = 1'b0;
    checkOutput("grantCount", 32'(ng), 32'd4);
    checkOutput("grant0Fetch", 32'(g[0]), 32'd1);
    checkOutput("grant1Loader", 32'(g[1]), 32'd0);
    checkOutput("grant2Fetch", 32'(g[2]), 32'd1);
    checkOutput("grant3Loader", 32'(g[3]), 32'd0);

    loadByte(AW'(7'h20), 8'hDE);
    loadByte(AW'(7'h21), 8'hAD);
    loadByte(AW'(7'h22), 8'hBE);
    loadByte(AW'(7'h23), 8'hEF);
    fetchWord(32'h20, instr, err, lat);
    checkOutput("loadedInstr", instr, 32'hDEADBEEF);

    // Response held for ten cycles with a competing request waiting.
    startFetch(32'h8);
    req_valid = 1'b1; req_addr = 32'h0;
    waitResp(lat);
    for (int c = 0; c < 10; c++) begin
      checkOutput("stallValid", 32'(resp_valid), 32'd1);
      checkOutput("stallInstr", resp_instr, 32'h12345678);
      checkOutput("stallReqReady", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    finishResp();

    // Reset while the third byte read is on the port.
    startFetch(32'h20);
    tick();
    tick();
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midReadAddr", 32'(mem_addr), 32'h22);
    tick();
    rst = 1'b0;
    @(negedge clk);
    checkOutput("abortRespValid", 32'(resp_valid), 32'd0);
    checkOutput("abortRdEn", 32'(mem_rd_en), 32'd0);
    checkOutput("abortAddr", 32'(mem_addr), 32'd0);
    checkOutput("abortInstr", resp_instr, 32'h0);
    checkOutput("abortErr", 32'(resp_err), 32'd0);
    tick();
    fetchWord(32'h20, instr, err, lat);
    checkOutput("postAbortInstr", instr, 32'hDEADBEEF);
    checkOutput("postAbortLatency", 32'(lat), 32'd6);

    // Randomized traffic against the model.
    for (int c = 0; c < 2000; c++) begin
      kind = int'($urandom_range(0, 5));
      case (kind)
        0, 1, 2: ra = 32'($urandom_range(0, 31) * 4);
        3:       ra = 32'($urandom_range(0, 127)) | 32'd1;
        4:       ra = ($urandom_range(0, 1) == 0) ? 32'h7C : 32'h80;
        default: ra = $urandom;
      endcase
      applyStimulus($urandom_range(0, 99) < 50, ra, $urandom_range(0, 99) < 40,
                    AW'($urandom), 8'($urandom), $urandom_range(0, 99) < 70,
                    $urandom_range(0, 299) == 0);
      tick();
    end
    applyStimulus(1'b0, 32'h0, 1'b0, '0, 8'h00, 1'b1, 1'b0);
    repeat (10) tick();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
